// File: rtl/bcd_display_scan.sv
// bcd_display_scan
//   Time-multiplexed 4-digit seven-segment driver for a packed-BCD value.
//   Loads are staged and only committed to the displayed value at a frame
//   boundary, so a frame never mixes digits from two different results.
//
// Parameters
//   SCAN_DIV  clock cycles per digit slot (>= 2)
//   DEAD      blanking cycles at the start of each slot (0 <= DEAD < SCAN_DIV)
//   BLANK_LZ  1: blank leading zeros on digits 3..1; 0: light all four digits
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bcd_in      four BCD digits, [3:0] units .. [15:12] thousands
//   load        capture strobe for bcd_in
//   seg_n       active-low segments {g,f,e,d,c,b,a}
//   an_n        active-low digit enables, bit k = digit k
//   err         displayed value holds a nibble > 9
//   frame_tick  one-cycle pulse on the first cycle of each frame

// Per-digit helper: seven-segment decode, leading-zero blank and bad-nibble flag.
module bcd_display_scan_digit #(
  parameter int K        = 0,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic [3:0] nib_i,
  input  logic       hi_zero_i,  // every digit above this one is zero
  output logic [6:0] seg_o,
  output logic       blank_o,
  output logic       bad_o
);
  // Digit 0 is always lit, so a zero value still shows "0".
  assign blank_o = BLANK_LZ && (K >= 1) && hi_zero_i && (nib_i == 4'd0);
  assign bad_o   = (nib_i > 4'd9);

  always_comb begin
    seg_o = 7'b0111111;  // dash for 10..15
    case (nib_i)
      4'd0: seg_o = 7'b1000000;
      4'd1: seg_o = 7'b1111001;
      4'd2: seg_o = 7'b0100100;
      4'd3: seg_o = 7'b0110000;
      4'd4: seg_o = 7'b0011001;
      4'd5: seg_o = 7'b0010010;
      4'd6: seg_o = 7'b0000010;
      4'd7: seg_o = 7'b1111000;
      4'd8: seg_o = 7'b0000000;
      4'd9: seg_o = 7'b0010000;
      default: seg_o = 7'b0111111;
    endcase
  end
endmodule

module bcd_display_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEAD     = 2,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        load,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        err,
  output logic        frame_tick
);
  localparam int            CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     pend_reg_q, pend_reg_d;
  logic            pend_q, pend_d;
  logic [15:0]     disp_q, disp_d;
  logic            err_q, err_d;
  logic            tick_q;
  logic [6:0]      seg_n_q, seg_n_d;
  logic [3:0]      an_n_q, an_n_d;

  logic            slot_end, boundary, commit, in_dead;
  logic [3:0]      blank, bad;
  logic [3:0][6:0] dig_seg;

  // Scan counters, load staging and frame-boundary commit.
  always_comb begin
    slot_end   = (cnt_q == CNT_MAX);
    boundary   = slot_end && (idx_q == 2'd3);
    cnt_d      = slot_end ? '0 : cnt_q + CW'(1);
    idx_d      = slot_end ? idx_q + 2'd1 : idx_q;

    pend_reg_d = pend_reg_q;
    pend_d     = pend_q;
    disp_d     = disp_q;
    commit     = 1'b0;
    if (boundary) begin
      pend_d = 1'b0;
      // A load on the boundary edge itself goes straight to the display.
      if (load) begin
        disp_d = bcd_in;
        commit = 1'b1;
      end else if (pend_q) begin
        disp_d = pend_reg_q;
        commit = 1'b1;
      end
    end else if (load) begin
      pend_reg_d = bcd_in;
      pend_d     = 1'b1;
    end
  end

  // Digits decode the next display value so the registered outputs line up
  // with the post-edge cnt/idx, including a commit on the same edge.
  for (genvar k = 0; k < 4; k++) begin : g_dig
    logic hi_zero;
    if (k == 3) begin : g_top
      assign hi_zero = 1'b1;
    end else begin : g_low
      assign hi_zero = (disp_d[15:4*(k+1)] == '0);
    end
    bcd_display_scan_digit #(.K(k), .BLANK_LZ(BLANK_LZ)) u_digit (
      .nib_i     (disp_d[4*k +: 4]),
      .hi_zero_i (hi_zero),
      .seg_o     (dig_seg[k]),
      .blank_o   (blank[k]),
      .bad_o     (bad[k])
    );
  end

  if (DEAD == 0) begin : g_nodead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = (cnt_d < CW'(DEAD));
  end

  always_comb begin
    err_d   = commit ? (|bad) : err_q;
    an_n_d  = 4'hF;
    seg_n_d = 7'h7F;
    if (!in_dead && !blank[idx_d]) begin
      an_n_d[idx_d] = 1'b0;
      seg_n_d       = dig_seg[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      pend_reg_q <= 16'h0;
      pend_q     <= 1'b0;
      disp_q     <= 16'h0;
      err_q      <= 1'b0;
      tick_q     <= 1'b0;
      an_n_q     <= 4'hF;
      seg_n_q    <= 7'h7F;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_reg_q <= pend_reg_d;
      pend_q     <= pend_d;
      disp_q     <= disp_d;
      err_q      <= err_d;
      tick_q     <= boundary;
      an_n_q     <= an_n_d;
      seg_n_q    <= seg_n_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign err        = err_q;
  assign frame_tick = tick_q;
endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Registered, time-multiplexed 4-digit seven-segment driver for the 16-bit packed-BCD sum produced by the 3-digit BCD adder. It sits directly downstream of the adder and latches results on a load strobe. Latched values are committed only at frame boundaries, so the display never shows a torn result. The block blanks leading zeros and flags invalid BCD nibbles.

## Interface
- SCAN_DIV, 1000: clock cycles per digit slot; must be ≥ 2.
- DEAD, 2: blanking cycles at the start of each slot (anti-ghosting); must satisfy 0 ≤ DEAD < SCAN_DIV.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 lights all four digits.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- bcd_in  in  16  four BCD digits; [3:0] is units, [15:12] is thousands (the adder carry digit).
- load  in  1  capture strobe; bcd_in is sampled on any edge where load=1.
- seg_n  out  7  active-low segments; bit order {g,f,e,d,c,b,a}.
- an_n  out  4  active-low digit enables; bit k drives digit k.
- err  out  1  high while the displayed value contains a nibble > 9.
- frame_tick  out  1  one-cycle pulse when a new frame starts.

## Operation
- State registers:
  - cnt, 0..SCAN_DIV-1
  - idx, 0..3
  - pend_reg[15:0] and pend flag
  - disp_reg[15:0]
  - err
  - frame_tick
  - seg_n and an_n, both registered
- cnt increments every cycle. At SCAN_DIV-1, cnt wraps to 0 and idx increments (3 wraps to 0).
- Frame boundary: the edge where cnt==SCAN_DIV-1 and idx==3.
- Load:
  - load=1 away from a boundary sets pend_reg←bcd_in and pend←1.
  - A later load before the boundary overwrites pend_reg; last load wins.
- Commit at a frame boundary:
  - If load=1 on that edge: disp_reg←bcd_in and pend←0. The coincident load bypasses pend_reg.
  - Else if pend=1: disp_reg←pend_reg and pend←0.
  - Otherwise disp_reg is unchanged.
- err is updated only on a commit: err←1 if any nibble of the committed value is > 9, else 0.
- Digit k is blank when BLANK_LZ=1, k ≥ 1, and nibbles k..3 of disp_reg are all zero. Digit 0 is never blanked.
- Registered outputs, aligned with the post-edge cnt and idx:
  - an_n: all ones while cnt < DEAD or the current digit is blank. Otherwise only bit idx is low.
  - seg_n: decode of nibble idx when that digit is enabled, else 7'h7F.
- Decode (seg_n, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = 0111111 (dash; only g lit)
- frame_tick is 1 on the cycle after a frame boundary edge (cnt=0, idx=0), and 0 otherwise.

## Timing
- Reset (asynchronous, rst_n=0) forces:
  - cnt=0, idx=0, disp_reg=0, pend_reg=0, pend=0
  - err=0, frame_tick=0, an_n=4'hF, seg_n=7'h7F
- First edge after rst_n rises: cnt=1, idx=0. The first frame displays 0000, i.e. digit 0 shows "0" and digits 3..1 are blanked when BLANK_LZ=1.
- Frame length: 4·SCAN_DIV cycles.
- Load-to-display latency:
  - Minimum 1 cycle, for a load coincident with a boundary.
  - Maximum 4·SCAN_DIV cycles.
- A change of disp_reg first appears in the slot for idx=0. The same frame never mixes old and new digits.
- Reset asserted mid-frame discards the pending load immediately. Outputs return to their reset values with no clock required.
- load while rst_n=0 is ignored.

## Test plan
(SCAN_DIV=4, DEAD=1, BLANK_LZ=1 unless noted.)
- Reset and release:
  - During reset: an_n=1111, seg_n=1111111, err=0.
  - Slot 0, cnt ≥ 1: an_n=1110, seg_n=1000000.
  - Slots 1–3: an_n=1111.
  - frame_tick pulses every 16 cycles.
- Mid-frame load of 16'h0512 during slot 1:
  - Current frame is unchanged.
  - Next frame: digit 2=0010010, digit 1=1111001, digit 0=0100100.
  - Digit 3 is blanked (an_n=1111 throughout slot 3).
- Embedded zeros, 16'h1002:
  - All four digits are enabled in turn; digits 2 and 1 show 1000000.
  - Repeat with BLANK_LZ=0 and 16'h0002: digit 3 is enabled showing 1000000.
- Back-to-back loads in one frame, 16'h0123 then 16'h0999: only 0999 is ever displayed.
- Coincident load: 16'h0042 with load on the boundary edge.
  - The next cycle has frame_tick=1, and 0042 shows in that same frame.
  - pend=0 afterwards.
- Invalid BCD:
  - Load 16'h00A3: after commit, err=1 and digit 1 shows 0111111.
  - Then load 16'h0003: err clears at the next boundary, not before.
  - Assert rst_n=0 mid-slot 2: all outputs return to reset values asynchronously.
